// File: rtl/flag_gen.sv
// rtl/flag_gen.sv - Condition-flag generator: registers Z/V/N from ALU results.
// Optional build macro: FLAG_GEN_BYPASS_EN removes the S1 capture stage.
module flag_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] res,
  input  logic             hold,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             out_valid,
  output logic             flags_pending
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NONE = 2'b11;

  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             n_q, n_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [1:0]       f_op;
  logic [WIDTH-1:0] f_a, f_b, f_res;
  logic             f_write;

`ifndef FLAG_GEN_BYPASS_EN
  typedef enum logic {S1_EMPTY, S1_FULL} s1_state_e;

  s1_state_e        s1_state_q, s1_state_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] s1_res_q, s1_res_d;
  logic             s1_valid;
  logic             drain;

  assign s1_valid      = (s1_state_q == S1_FULL);
  assign in_ready      = !s1_valid || !hold;
  assign accept        = in_valid && in_ready;
  assign drain         = s1_valid && !hold;
  assign flags_pending = s1_valid && (s1_op_q != OP_NONE);

  // A drain and an accept in the same cycle keep S1 full with the new op.
  always_comb begin
    s1_state_d = s1_state_q;
    case (s1_state_q)
      S1_EMPTY: if (accept)          s1_state_d = S1_FULL;
      S1_FULL:  if (drain && !accept) s1_state_d = S1_EMPTY;
      default:                       s1_state_d = S1_EMPTY;
    endcase
  end

  always_comb begin
    s1_op_d  = s1_op_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_res_d = s1_res_q;
    if (accept) begin
      s1_op_d  = op;
      s1_a_d   = a;
      s1_b_d   = b;
      s1_res_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_state_q <= S1_EMPTY;
      s1_op_q    <= OP_NONE;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_res_q   <= '0;
    end else begin
      s1_state_q <= s1_state_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_res_q   <= s1_res_d;
    end
  end

  assign f_op    = s1_op_q;
  assign f_a     = s1_a_q;
  assign f_b     = s1_b_q;
  assign f_res   = s1_res_q;
  assign f_write = drain && (s1_op_q != OP_NONE);
`else
  assign in_ready      = !hold;
  assign accept        = in_valid && in_ready;
  assign flags_pending = 1'b0;

  assign f_op    = op;
  assign f_a     = a;
  assign f_b     = b;
  assign f_res   = res;
  assign f_write = accept && (op != OP_NONE);
`endif

  // res is trusted; overflow is inferred from operand and result sign bits only.
  always_comb begin
    z_d         = z_q;
    v_d         = v_q;
    n_d         = n_q;
    out_valid_d = f_write;
    if (f_write) begin
      z_d = (f_res == '0);
      n_d = f_res[WIDTH-1];
      case (f_op)
        OP_ADD:  v_d = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (f_res[WIDTH-1] != f_a[WIDTH-1]);
        OP_SUB:  v_d = (f_a[WIDTH-1] != f_b[WIDTH-1]) && (f_res[WIDTH-1] != f_a[WIDTH-1]);
        default: v_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      z_q         <= z_d;
      v_q         <= v_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign z         = z_q;
  assign v         = v_q;
  assign n         = n_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_flag_gen.sv
// tb/tb_flag_gen.sv - Self-checking bench for flag_gen (default two-stage build).
module tb_flag_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] a, b, res;
  logic        hold;
  logic        z, v, n;
  logic        out_valid;
  logic        flags_pending;

  int total = 0;
  int bad   = 0;

  flag_gen #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .res(res), .hold(hold),
    .z(z), .v(v), .n(n), .out_valid(out_valid), .flags_pending(flags_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: flags derived from the signed meaning of operands and result.
  function automatic logic [2:0] ref_flags(input logic [1:0] o, input logic [15:0] ra,
                                           input logic [15:0] rb, input logic [15:0] rr);
    bit na, nb, nr, fz, fv;
    na = $signed(ra) < 0;
    nb = $signed(rb) < 0;
    nr = $signed(rr) < 0;
    fz = (rr == 16'd0);
    if (o == 2'd0)      fv = (na == nb) && (nr != na);
    else if (o == 2'd1) fv = (na != nb) && (nr != na);
    else                fv = 1'b0;
    return {fz, fv, nr};
  endfunction

  // Model: a one-entry holding slot plus the published flags.
  logic        m_full;
  logic [1:0]  m_op;
  logic [15:0] m_a, m_b, m_res;
  logic [2:0]  m_flags;
  logic        m_ov;
  wire         m_ready = !m_full || !hold;
  wire         m_acc   = in_valid && m_ready;
  wire         m_drn   = m_full && !hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full  <= 1'b0;
      m_op    <= 2'd3;
      m_a     <= '0;
      m_b     <= '0;
      m_res   <= '0;
      m_flags <= 3'b000;
      m_ov    <= 1'b0;
    end else begin
      m_ov <= m_drn && (m_op != 2'd3);
      if (m_drn && (m_op != 2'd3)) m_flags <= ref_flags(m_op, m_a, m_b, m_res);
      if (m_acc) begin
        m_full <= 1'b1;
        m_op   <= op;
        m_a    <= a;
        m_b    <= b;
        m_res  <= res;
      end else if (m_drn) begin
        m_full <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("model_flags", {29'd0, z, v, n}, {29'd0, m_flags});
    check("model_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("model_in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    check("model_pending", {31'd0, flags_pending}, {31'd0, m_full && (m_op != 2'd3)});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] o, input logic [15:0] ra, input logic [15:0] rb,
                       input logic [15:0] rr);
    in_valid = 1'b1;
    op  = o;
    a   = ra;
    b   = rb;
    res = rr;
  endtask

  task automatic check_flags(input string name, input logic [2:0] exp);
    check(name, {29'd0, z, v, n}, {29'd0, exp});
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; in_valid = 1'b0; op = 2'd3; a = '0; b = '0; res = '0; hold = 1'b0;
    #2;
    check_flags("reset_flags", 3'b000);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_pending", {31'd0, flags_pending}, 32'd0);
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    step();
    check_flags("post_reset_flags", 3'b000);

    // ADD overflow into the sign bit
    drive(2'd0, 16'h7FFF, 16'h0001, 16'h8000);
    step();
    in_valid = 1'b0;
    check("add_pending_k", {31'd0, flags_pending}, 32'd1);
    check("add_ov_k", {31'd0, out_valid}, 32'd0);
    step();
    check_flags("add_flags", 3'b011);
    check("add_ov_k1", {31'd0, out_valid}, 32'd1);
    check("add_pending_k1", {31'd0, flags_pending}, 32'd0);
    step();
    check("add_ov_k2", {31'd0, out_valid}, 32'd0);

    drive(2'd1, 16'h1234, 16'h1234, 16'h0000);
    step(); in_valid = 1'b0; step();
    check_flags("sub_zero", 3'b100);
    drive(2'd1, 16'h8000, 16'h0001, 16'h7FFF);
    step(); in_valid = 1'b0; step();
    check_flags("sub_ovf", 3'b010);

    drive(2'd2, 16'h7FFF, 16'h7FFF, 16'hF000);
    step(); in_valid = 1'b0; step();
    check_flags("logic_neg", 3'b001);
    drive(2'd3, 16'h0000, 16'h0000, 16'h0000);
    step(); in_valid = 1'b0;
    check("none_pending", {31'd0, flags_pending}, 32'd0);
    step();
    check("none_ov", {31'd0, out_valid}, 32'd0);
    check_flags("none_flags", 3'b001);

    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(2'd0, 16'h1000 * i[15:0], 16'h0100, 16'h1000 * i[15:0] + 16'h0100);
      step();
      check("b2b_ready", {31'd0, in_ready}, 32'd1);
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    step();
    if (out_valid) pulses++;
    check_flags("b2b_last", 3'b000);
    check("b2b_pulses", pulses, 32'd5);
    step();

    hold = 1'b1;
    drive(2'd1, 16'h0005, 16'h0005, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      in_valid = 1'b0;
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      check("hold_z", {31'd0, z}, 32'd0);
      check("hold_pending", {31'd0, flags_pending}, 32'd1);
    end
    hold = 1'b0;
    step();
    check("hold_release_z", {31'd0, z}, 32'd1);
    check("hold_release_ready", {31'd0, in_ready}, 32'd1);

    drive(2'd0, 16'h7FFF, 16'h0001, 16'h8000);
    step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_flags("rst_mid_flags", 3'b000);
    check("rst_mid_ov", {31'd0, out_valid}, 32'd0);
    check("rst_mid_pending", {31'd0, flags_pending}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step(); step();
    check_flags("rst_no_stale", 3'b000);
    check("rst_no_stale_ov", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(3) != 0);
      hold     = ($urandom_range(3) == 0);
      op       = 2'($urandom_range(3));
      a        = 16'($urandom);
      b        = 16'($urandom);
      case ($urandom_range(3))
        0:       res = a + b;
        1:       res = a - b;
        2:       res = 16'd0;
        default: res = 16'($urandom);
      endcase
      step();
    end
    in_valid = 1'b0;
    hold = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
